// File: rtl/reg_dump_reader_if.sv
// Output word stream of the register dump reader: one register value per transfer.
// Transfers complete on dump_valid && dump_ready; dump_last marks the final register of the range.
interface reg_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;

    modport master (
        output dump_valid,
        input  dump_ready,
        output dump_addr,
        output dump_data,
        output dump_last
    );

    modport slave (
        input  dump_valid,
        output dump_ready,
        input  dump_addr,
        input  dump_data,
        input  dump_last
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks a register address range through the debug read port and streams each value out, with XOR checksum and word count.
// Latency: first word valid 2 cycles after start; one word per 2 cycles at full throughput; done 1 cycle after the last handshake.
// Backpressure: a presented word holds stable until dump_ready; the walk stalls meanwhile.
module reg_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] debug_reg_ra,
    input  logic [DATA_W-1:0] debug_reg_rd,
    reg_dump_reader_if.master dump,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_q,      state_d;
    logic [ADDR_W-1:0] cur_addr_q,   cur_addr_d;
    logic [ADDR_W-1:0] end_addr_q,   end_addr_d;
    logic [DATA_W-1:0] dump_data_q,  dump_data_d;
    logic [ADDR_W-1:0] dump_addr_q,  dump_addr_d;
    logic              dump_last_q,  dump_last_d;
    logic [DATA_W-1:0] checksum_q,   checksum_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        end_addr_d   = end_addr_q;
        dump_data_d  = dump_data_q;
        dump_addr_d  = dump_addr_q;
        dump_last_d  = dump_last_q;
        checksum_d   = checksum_q;
        word_count_d = word_count_q;

        case (state_q)
            ST_IDLE: begin
                // abort alongside start keeps the block idle
                if (start && !abort) begin
                    state_d      = ST_READ;
                    cur_addr_d   = start_addr;
                    end_addr_d   = end_addr;
                    checksum_d   = '0;
                    word_count_d = '0;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    dump_data_d = debug_reg_rd;
                    dump_addr_d = cur_addr_q;
                    dump_last_d = (cur_addr_q == end_addr_q);
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (dump.dump_ready) begin
                    checksum_d   = checksum_q ^ dump_data_q;
                    word_count_d = word_count_q + {{ADDR_W{1'b0}}, 1'b1};
                    if (dump_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        // wraps modulo 2^ADDR_W so start > end walks through the top of the file
                        cur_addr_d = cur_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_d    = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            end_addr_q   <= '0;
            dump_data_q  <= '0;
            dump_addr_q  <= '0;
            dump_last_q  <= 1'b0;
            checksum_q   <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            end_addr_q   <= end_addr_d;
            dump_data_q  <= dump_data_d;
            dump_addr_q  <= dump_addr_d;
            dump_last_q  <= dump_last_d;
            checksum_q   <= checksum_d;
            word_count_q <= word_count_d;
        end
    end

    // cur_addr only moves on start or after a handshake, so it already holds steady in IDLE/DONE
    assign debug_reg_ra    = cur_addr_q;
    assign dump.dump_valid = (state_q == ST_OUT);
    assign dump.dump_addr  = dump_addr_q;
    assign dump.dump_data  = dump_data_q;
    assign dump.dump_last  = dump_last_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign checksum        = checksum_q;
    assign word_count      = word_count_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: expected words queued by stimulus, popped by a handshake monitor.
module tb_reg_dump_reader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] debug_reg_ra;
    logic [DATA_W-1:0] debug_reg_rd;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;
    logic [ADDR_W:0]   word_count;

    logic [DATA_W-1:0] regs [32];
    exp_t              exp_q [$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                last_hs_cyc = -100;

    reg_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif ();

    reg_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .debug_reg_ra (debug_reg_ra),
        .debug_reg_rd (debug_reg_rd),
        .dump         (dif),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum),
        .word_count   (word_count)
    );

    assign debug_reg_rd = regs[debug_reg_ra];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea);
        start_addr = sa;
        end_addr   = ea;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic push_range(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea);
        logic [ADDR_W-1:0] a;
        a = sa;
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back('{addr: a, data: regs[a], last: (a == ea)});
            if (a == ea) break;
            a = a + 5'd1;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({name, "_done_latency"}, 64'(cyc), 64'(last_hs_cyc + 1));
            tick();
            chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
            chk({name, "_idle_after_done"}, 64'(busy), 64'd0);
        end
        chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Handshake monitor: every accepted word must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && dif.dump_valid === 1'b1 && dif.dump_ready === 1'b1 && abort !== 1'b1) begin
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'(dif.dump_addr), 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word_addr", 64'(dif.dump_addr), 64'(e.addr));
                chk("word_data", 64'(dif.dump_data), 64'(e.data));
                chk("word_last", 64'(dif.dump_last), 64'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[1] = 32'h1000_0000;
        regs[2] = 32'h0000_0005;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        start_addr = '0; end_addr = '0;
        dif.dump_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 64'(dif.dump_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ra", 64'(debug_reg_ra), 64'd0);
        chk("rst_data", 64'(dif.dump_data), 64'd0);
        chk("rst_count", 64'(word_count), 64'd0);
        rst = 1'b0;
        tick();

        // Full dump 0..31
        push_range(5'd0, 5'd31);
        do_start(5'd0, 5'd31);
        wait_done("full", 200);
        chk("full_checksum", 64'(checksum), 64'h1000_0005);
        chk("full_count", 64'(word_count), 64'd32);

        // Back-pressure on a 2-word range
        dif.dump_ready = 1'b0;
        push_range(5'd2, 5'd3);
        do_start(5'd2, 5'd3);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(dif.dump_valid), 64'd1);
            chk("bp_addr", 64'(dif.dump_addr), 64'd2);
            chk("bp_data", 64'(dif.dump_data), 64'h5);
            chk("bp_count", 64'(word_count), 64'd0);
            tick();
        end
        dif.dump_ready = 1'b1;
        wait_done("bp", 50);
        chk("bp_final_count", 64'(word_count), 64'd2);
        chk("bp_checksum", 64'(checksum), 64'h5);

        // Wrap-around 30,31,0,1
        regs[30] = 32'h0000_00F0;
        regs[31] = 32'h0000_0F00;
        push_range(5'd30, 5'd1);
        do_start(5'd30, 5'd1);
        wait_done("wrap", 50);
        chk("wrap_count", 64'(word_count), 64'd4);
        chk("wrap_checksum", 64'(checksum), 64'h1000_0FF0);
        regs[30] = '0;
        regs[31] = '0;

        // Single word and first-word latency
        push_range(5'd1, 5'd1);
        do_start(5'd1, 5'd1);
        chk("lat_valid_n1", 64'(dif.dump_valid), 64'd0);
        tick();
        chk("lat_valid_n2", 64'(dif.dump_valid), 64'd1);
        chk("lat_last", 64'(dif.dump_last), 64'd1);
        chk("lat_data", 64'(dif.dump_data), 64'h1000_0000);
        tick();
        chk("single_done", 64'(done), 64'd1);
        wait_done("single", 10);
        chk("single_checksum", 64'(checksum), 64'h1000_0000);
        chk("single_count", 64'(word_count), 64'd1);

        // start with abort in IDLE stays idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("idle_start_abort", 64'(busy), 64'd0);

        // Abort on the 4th OUT; a stray start mid-dump is ignored
        for (int k = 0; k < 3; k++) exp_q.push_back('{addr: 5'(k), data: regs[k], last: 1'b0});
        do_start(5'd0, 5'd31);
        tick();
        tick();
        start_addr = 5'd20; end_addr = 5'd20; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("abort_pre_valid", 64'(dif.dump_valid), 64'd1);
        chk("abort_pre_addr", 64'(dif.dump_addr), 64'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(dif.dump_valid), 64'd0);
        chk("abort_count", 64'(word_count), 64'd3);
        chk("abort_checksum", 64'(checksum), 64'h1000_0005);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", 64'(done), 64'd0);
            tick();
        end
        chk("abort_queue", 64'(exp_q.size()), 64'd0);

        // Reset while in READ, then a normal dump
        do_start(5'd5, 5'd7);
        chk("rst_mid_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstm_busy", 64'(busy), 64'd0);
        chk("rstm_valid", 64'(dif.dump_valid), 64'd0);
        chk("rstm_ra", 64'(debug_reg_ra), 64'd0);
        chk("rstm_addr", 64'(dif.dump_addr), 64'd0);
        chk("rstm_data", 64'(dif.dump_data), 64'd0);
        chk("rstm_last", 64'(dif.dump_last), 64'd0);
        chk("rstm_checksum", 64'(checksum), 64'd0);
        chk("rstm_count", 64'(word_count), 64'd0);
        push_range(5'd1, 5'd2);
        do_start(5'd1, 5'd2);
        wait_done("after_rst", 50);
        chk("after_rst_count", 64'(word_count), 64'd2);
        chk("after_rst_checksum", 64'(checksum), 64'h1000_0005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
